// File: rtl/dfd_pixel_stream_tx.sv
// dfd_pixel_stream_tx: source end of the DFD pixel-stream interface.
// Tags each accepted fp16 depth/confidence sample with raster coordinates
// and end-of-line/end-of-frame flags. Output is registered, so latency is
// one cycle. Framing errors are reported through sticky flags.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for SOF; non-SOF samples are dropped as orphans
// ACTIVE | inside a frame; col_q/row_q hold the next coordinate to emit
//
// Only DIM_W = 16 is supported, since the downstream interface is fixed at 16.
module dfd_pixel_stream_tx #(
  parameter int DIM_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [15:0]      data_i,
  input  logic [15:0]      confidence_i,
  input  logic             sof_i,
  input  logic             valid_i,
  input  logic [DIM_W-1:0] width_i,
  input  logic [DIM_W-1:0] height_i,
  input  logic             clear_err_i,
  output logic [15:0]      data_o,
  output logic [15:0]      confidence_o,
  output logic [DIM_W-1:0] col_o,
  output logic [DIM_W-1:0] row_o,
  output logic             valid_o,
  output logic             eol_o,
  output logic             eof_o,
  output logic [15:0]      frame_count_o,
  output logic             busy_o,
  output logic             err_orphan_o,
  output logic             err_early_sof_o,
  output logic             err_cfg_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q;
  logic [DIM_W-1:0] col_q;
  logic [DIM_W-1:0] row_q;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;

  logic [DIM_W-1:0] w_m1;
  logic [DIM_W-1:0] h_m1;
  logic             col_last;
  logic             row_last;
  logic             sof_cfg_ok;
  logic             sof_w1;
  logic             sof_h1;

  // Terminal-coordinate compares against the latched dimensions, and SOF checks.
  assign w_m1       = w_q - DIM_W'(1);
  assign h_m1       = h_q - DIM_W'(1);
  assign col_last   = (col_q == w_m1);
  assign row_last   = (row_q == h_m1);
  assign sof_cfg_ok = (width_i != '0) && (height_i != '0);
  assign sof_w1     = (width_i == DIM_W'(1));
  assign sof_h1     = (height_i == DIM_W'(1));

  // busy_o is a direct decode of the registered state.
  assign busy_o = (state_q == ACTIVE);

  // Framing FSM, coordinate counters, registered output stage and error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      col_q           <= '0;
      row_q           <= '0;
      w_q             <= '0;
      h_q             <= '0;
      data_o          <= '0;
      confidence_o    <= '0;
      col_o           <= '0;
      row_o           <= '0;
      valid_o         <= 1'b0;
      eol_o           <= 1'b0;
      eof_o           <= 1'b0;
      frame_count_o   <= '0;
      err_orphan_o    <= 1'b0;
      err_early_sof_o <= 1'b0;
      err_cfg_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;

      // Clear first so a coincident error event below overrides it.
      if (clear_err_i) begin
        err_orphan_o    <= 1'b0;
        err_early_sof_o <= 1'b0;
        err_cfg_o       <= 1'b0;
      end

      if (valid_i) begin
        if (sof_i) begin
          // An SOF inside a frame abandons that frame without eof or count.
          if (state_q == ACTIVE) begin
            err_early_sof_o <= 1'b1;
          end
          if (!sof_cfg_ok) begin
            err_cfg_o <= 1'b1;
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
          end else begin
            w_q          <= width_i;
            h_q          <= height_i;
            data_o       <= data_i;
            confidence_o <= confidence_i;
            col_o        <= '0;
            row_o        <= '0;
            valid_o      <= 1'b1;
            eol_o        <= sof_w1;
            eof_o        <= sof_w1 && sof_h1;
            if (sof_w1 && sof_h1) begin
              frame_count_o <= frame_count_o + 16'd1;
              state_q       <= IDLE;
              col_q         <= '0;
              row_q         <= '0;
            end else if (sof_w1) begin
              state_q <= ACTIVE;
              col_q   <= '0;
              row_q   <= DIM_W'(1);
            end else begin
              state_q <= ACTIVE;
              col_q   <= DIM_W'(1);
              row_q   <= '0;
            end
          end
        end else if (state_q == IDLE) begin
          err_orphan_o <= 1'b1;
        end else begin
          data_o       <= data_i;
          confidence_o <= confidence_i;
          col_o        <= col_q;
          row_o        <= row_q;
          valid_o      <= 1'b1;
          eol_o        <= col_last;
          eof_o        <= col_last && row_last;
          if (col_last) begin
            col_q <= '0;
            if (row_last) begin
              row_q         <= '0;
              frame_count_o <= frame_count_o + 16'd1;
              state_q       <= IDLE;
            end else begin
              row_q <= row_q + DIM_W'(1);
            end
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
      end
    end
  end

endmodule
